uart_temp_tx_sched: RTL and testbench

//  Shares one byte-level UART transmitter between NUM_CH low-period measurement channels.

---
 rtl/uart_temp_pkg.sv | 29 ++
 rtl/uart_temp_tx_sched_rr_arb.sv | 31 +++
 rtl/uart_temp_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_uart_temp_tx_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_temp_pkg.sv
// Shared ASCII constants, frame state encoding and nibble-to-hex helper for the temperature UART scheduler.
package uart_temp_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_ID  = 3'd1,
        ST_SEND_SEP = 3'd2,
        ST_SEND_HEX = 3'd3,
        ST_SEND_CR  = 3'd4,
        ST_SEND_LF  = 3'd5
    } frame_state_t;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + ({4'h0, nib} - 8'd10);
    endfunction

endpackage

// File: rtl/uart_temp_tx_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester after last_grant, wrapping.
module uart_temp_rr_arb
    import uart_temp_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any
);

    // Scan offsets 1..NUM_CH from the pointer; the first hit wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (!any && req[k] && (((32'(last_grant) + off) % NUM_CH) == k)) begin
                    any           = 1'b1;
                    gnt_idx       = CH_W'(k);
                    gnt_onehot[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_temp_tx_sched.sv
// Round-robin scheduler that frames each granted channel count as "<id>:<hex>\r\n" onto a byte UART.
module uart_temp_tx_sched
    import uart_temp_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned COUNT_WIDTH = 32,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_valid_i,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] ch_count_i,
    output logic [NUM_CH-1:0]             ch_ready_o,
    output logic [7:0]                    tx_byte_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    output logic                          busy_o,
    output logic [CH_W-1:0]               active_ch_o
);

    localparam int unsigned HEX_DIGITS = COUNT_WIDTH / 4;
    localparam int unsigned NIB_W      = (HEX_DIGITS > 1) ? $clog2(HEX_DIGITS) : 1;

    frame_state_t           state_q, state_d;
    logic [CH_W-1:0]        last_grant_q, last_grant_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [NIB_W-1:0]       nib_q, nib_d;
    logic [NUM_CH-1:0]      ch_ready_q, ch_ready_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   busy_q, busy_d;
    logic [CH_W-1:0]        active_ch_q, active_ch_d;

    logic [NUM_CH-1:0]      gnt_onehot;
    logic [CH_W-1:0]        gnt_idx;
    logic                   gnt_any;
    logic [COUNT_WIDTH-1:0] gnt_count;
    logic                   xfer;
    logic [7:0]             top_hex;

    uart_temp_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req        (ch_valid_i),
        .last_grant (last_grant_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // Mux the granted channel's count using the one-hot grant.
    always_comb begin
        gnt_count = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            gnt_count = gnt_count | (ch_count_i[k*COUNT_WIDTH +: COUNT_WIDTH] & {COUNT_WIDTH{gnt_onehot[k]}});
        end
    end

    assign xfer    = tx_valid_q & tx_ready_i;
    // The latched count is shifted left per digit, so the next digit is always the top nibble.
    assign top_hex = nib2ascii(count_q[COUNT_WIDTH-1 -: 4]);

    // Next-state and output-register logic; the next byte is loaded on each transfer edge.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        nib_d        = nib_q;
        ch_ready_d   = '0;
        tx_byte_d    = tx_byte_q;
        tx_valid_d   = tx_valid_q;
        busy_d       = busy_q;
        active_ch_d  = active_ch_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    ch_ready_d   = gnt_onehot;
                    count_d      = gnt_count;
                    last_grant_d = gnt_idx;
                    active_ch_d  = gnt_idx;
                    busy_d       = 1'b1;
                    state_d      = ST_SEND_ID;
                end
            end
            ST_SEND_ID: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_byte_d  = ASCII_0 + 8'(active_ch_q);
                end else if (xfer) begin
                    tx_byte_d = ASCII_COLON;
                    state_d   = ST_SEND_SEP;
                end
            end
            ST_SEND_SEP: begin
                if (xfer) begin
                    tx_byte_d = top_hex;
                    count_d   = COUNT_WIDTH'(count_q << 4);
                    nib_d     = '0;
                    state_d   = ST_SEND_HEX;
                end
            end
            ST_SEND_HEX: begin
                if (xfer) begin
                    if (nib_q == NIB_W'(HEX_DIGITS - 1)) begin
                        tx_byte_d = ASCII_CR;
                        state_d   = ST_SEND_CR;
                    end else begin
                        tx_byte_d = top_hex;
                        count_d   = COUNT_WIDTH'(count_q << 4);
                        nib_d     = nib_q + NIB_W'(1);
                    end
                end
            end
            ST_SEND_CR: begin
                if (xfer) begin
                    tx_byte_d = ASCII_LF;
                    state_d   = ST_SEND_LF;
                end
            end
            ST_SEND_LF: begin
                if (xfer) begin
                    tx_byte_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= CH_W'(NUM_CH - 1);
            count_q      <= '0;
            nib_q        <= '0;
            ch_ready_q   <= '0;
            tx_byte_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            active_ch_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            nib_q        <= nib_d;
            ch_ready_q   <= ch_ready_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            active_ch_q  <= active_ch_d;
        end
    end

    assign ch_ready_o  = ch_ready_q;
    assign tx_byte_o   = tx_byte_q;
    assign tx_valid_o  = tx_valid_q;
    assign busy_o      = busy_q;
    assign active_ch_o = active_ch_q;

endmodule

// File: tb/tb_uart_temp_tx_sched.sv
// Directed plus randomized bench for uart_temp_tx_sched with a frame/round-robin reference model.
module tb_uart_temp_tx_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 32;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] ch_valid_i;
    logic [NCH*CW-1:0] ch_count_i;
    logic [NCH-1:0] ch_ready_o;
    logic [7:0]     tx_byte_o;
    logic           tx_valid_o;
    logic           tx_ready_i;
    logic           busy_o;
    logic [1:0]     active_ch_o;

    int vectors;
    int miscompares;
    int mp;

    uart_temp_tx_sched #(
        .NUM_CH      (NCH),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_valid_i  (ch_valid_i),
        .ch_count_i  (ch_count_i),
        .ch_ready_o  (ch_ready_o),
        .tx_byte_o   (tx_byte_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o),
        .active_ch_o (active_ch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: round-robin pick of the first valid channel after ptr.
    function automatic int rr(input logic [NCH-1:0] mask, input int ptr);
        for (int off = 1; off <= NCH; off++) begin
            int c;
            c = (ptr + off) % NCH;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // Reference: byte idx of the ASCII frame for channel id carrying cnt.
    function automatic logic [7:0] frame_byte(input int id, input logic [31:0] cnt, input int idx);
        int d;
        if (idx == 0) return 8'(48 + id);
        if (idx == 1) return 8'h3A;
        if (idx == 10) return 8'h0D;
        if (idx == 11) return 8'h0A;
        d = int'((cnt >> (4 * (9 - idx))) & 32'hF);
        if (d < 10) return 8'(48 + d);
        return 8'(65 + d - 10);
    endfunction

    task automatic set_count(input int ch, input logic [31:0] v);
        ch_count_i[ch*CW +: CW] = v;
    endtask

    task automatic wait_pulse();
        int w;
        w = 0;
        while (ch_ready_o == '0 && w < 60) begin
            tick();
            w++;
        end
    endtask

    // Await a grant for exp_ch and check the whole frame plus the byte-hold rule.
    task automatic expect_frame(input int exp_ch, input logic [31:0] cnt, input bit rnd,
                                input logic [NCH-1:0] next_valid, input logic [NCH-1:0] glitch);
        int n;
        int cycles;
        bit stall;
        logic [7:0] pb;
        wait_pulse();
        chk("grant_onehot", 32'(ch_ready_o), 32'(1) << exp_ch);
        chk("grant_busy", 32'(busy_o), 32'd1);
        chk("grant_active", 32'(active_ch_o), 32'(exp_ch));
        chk("grant_no_valid_yet", 32'(tx_valid_o), 32'd0);
        ch_valid_i = next_valid;
        tick();
        chk("pulse_one_cycle", 32'(ch_ready_o), 32'd0);
        chk("id_latency", 32'(tx_valid_o), 32'd1);
        n = 0;
        cycles = 0;
        stall = 1'b0;
        pb = 8'h00;
        while (n < 12 && cycles < 400) begin
            if (glitch != '0 && cycles == 3) ch_valid_i = glitch;
            if (glitch != '0 && cycles == 4) ch_valid_i = next_valid;
            tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) begin
                chk("hold_byte", 32'(tx_byte_o), 32'(pb));
                chk("hold_valid", 32'(tx_valid_o), 32'd1);
            end
            if (tx_valid_o && tx_ready_i) begin
                chk($sformatf("byte%0d", n), 32'(tx_byte_o), 32'(frame_byte(exp_ch, cnt, n)));
                n++;
            end
            stall = tx_valid_o && !tx_ready_i;
            pb = tx_byte_o;
            tick();
            cycles++;
        end
        chk("frame_len", 32'(n), 32'd12);
        if (!rnd) chk("back_to_back", 32'(cycles), 32'd12);
        chk("end_busy", 32'(busy_o), 32'd0);
        chk("end_valid", 32'(tx_valid_o), 32'd0);
        mp = exp_ch;
    endtask

    initial begin
        logic [31:0] cnt;
        logic [NCH-1:0] mask;
        int e;
        int n;
        int cycles;
        bit seen;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        ch_valid_i = '0;
        ch_count_i = '0;
        tx_ready_i = 1'b0;
        tick(); tick(); tick();
        chk("rst_ch_ready", 32'(ch_ready_o), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_active", 32'(active_ch_o), 32'd0);
        reset = 1'b0;
        mp = NCH - 1;

        // Single channel, fixed count, ready always high.
        set_count(0, 32'h0000_1A2F);
        ch_valid_i = 4'b0001;
        expect_frame(rr(4'b0001, mp), 32'h0000_1A2F, 1'b0, 4'b0000, 4'b0000);

        // All channels valid from reset: order 0,1,2,3,0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mp = NCH - 1;
        for (int k = 0; k < NCH; k++) set_count(k, $urandom);
        ch_valid_i = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            e = rr(4'b1111, mp);
            chk("order", 32'(e), 32'(f % NCH));
            expect_frame(e, ch_count_i[e*CW +: CW], 1'b0, (f == 4) ? 4'b0000 : 4'b1111, 4'b0000);
        end

        // All-F count under random backpressure.
        set_count(1, 32'hFFFF_FFFF);
        ch_valid_i = 4'b0010;
        expect_frame(rr(4'b0010, mp), 32'hFFFF_FFFF, 1'b1, 4'b0000, 4'b0000);

        // Wrap: after ch2, requests on 0 and 2 grant ch0 then ch2.
        for (int k = 0; k < NCH; k++) set_count(k, $urandom);
        ch_valid_i = 4'b0100;
        expect_frame(rr(4'b0100, mp), ch_count_i[2*CW +: CW], 1'b0, 4'b0101, 4'b0000);
        e = rr(4'b0101, mp);
        chk("wrap_to_0", 32'(e), 32'd0);
        expect_frame(e, ch_count_i[e*CW +: CW], 1'b0, 4'b0101, 4'b0000);
        e = rr(4'b0101, mp);
        chk("then_2", 32'(e), 32'd2);
        expect_frame(e, ch_count_i[e*CW +: CW], 1'b0, 4'b0000, 4'b0000);

        // Reset during the 5th byte aborts the frame.
        tx_ready_i = 1'b1;
        ch_valid_i = 4'b0001;
        wait_pulse();
        ch_valid_i = 4'b0000;
        cnt = ch_count_i[0 +: CW];
        n = 0;
        cycles = 0;
        while (n < 4 && cycles < 50) begin
            if (tx_valid_o && tx_ready_i) n++;
            tick();
            cycles++;
        end
        chk("byte5_offered", 32'(tx_byte_o), 32'(frame_byte(0, cnt, 4)));
        reset = 1'b1;
        tick();
        chk("abort_valid", 32'(tx_valid_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_byte", 32'(tx_byte_o), 32'd0);
        chk("abort_active", 32'(active_ch_o), 32'd0);
        ch_valid_i = 4'b1000;
        reset = 1'b0;
        mp = NCH - 1;
        set_count(3, $urandom);
        expect_frame(rr(4'b1000, mp), ch_count_i[3*CW +: CW], 1'b0, 4'b0000, 4'b0000);

        // ch1 glitches valid while busy: it must never be served.
        ch_valid_i = 4'b0001;
        expect_frame(rr(4'b0001, mp), ch_count_i[0 +: CW], 1'b0, 4'b0000, 4'b0010);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            seen = seen | (ch_ready_o != '0) | busy_o;
            tick();
        end
        chk("glitch_ignored", 32'(seen), 32'd0);

        // Random masks, counts and backpressure against the model.
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < NCH; k++) set_count(k, $urandom);
            mask = 4'($urandom_range(1, 15));
            ch_valid_i = mask;
            e = rr(mask, mp);
            expect_frame(e, ch_count_i[e*CW +: CW], 1'b1, 4'b0000, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
